// File: rtl/gain_sched_if.sv
// Stereo sample stream bundle for gain_sched: left/right inputs and the scaled output.
interface gain_sched_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] l_din;
  logic                  l_valid;
  logic                  l_ready;
  logic [DATA_WIDTH-1:0] r_din;
  logic                  r_valid;
  logic                  r_ready;
  logic [DATA_WIDTH-1:0] out_dout;
  logic                  out_ch;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output l_din, l_valid, r_din, r_valid, out_ready,
    input  l_ready, r_ready, out_dout, out_ch, out_valid
  );

  modport slave (
    input  l_din, l_valid, r_din, r_valid, out_ready,
    output l_ready, r_ready, out_dout, out_ch, out_valid
  );
endinterface

// File: rtl/gain_sched.sv
// Stereo gain scheduler: round-robin L/R into one Q10 multiplier, per-frame gain ramp.
// Define GAIN_SCHED_SAT_EN to saturate the shifted result instead of wrapping.
module gain_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int GAIN_WIDTH = 16,
  parameter int OUT_SHIFT  = 4,
  parameter int RAMP_STEP  = 64
) (
  input  logic                  clock,
  input  logic                  reset_n,
  gain_sched_if.slave           io,
  input  logic [GAIN_WIDTH-1:0] target_gain,
  input  logic                  mute,
  output logic [GAIN_WIDTH-1:0] gain_cur,
  output logic                  ramp_busy,
  output logic                  muted
);
  localparam int STAGES = 2;
  localparam int PW     = DATA_WIDTH + GAIN_WIDTH + 1;
  localparam logic [GAIN_WIDTH-1:0] STEP = GAIN_WIDTH'(RAMP_STEP);
  localparam logic signed [PW-1:0]  RND  = PW'(1023);

  typedef enum logic [1:0] {STEADY, RAMP_UP, RAMP_DOWN, MUTED} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] din;
    logic                  ch;
    logic [GAIN_WIDTH-1:0] gain;
  } s1_t;

  state_t                  state, state_nx;
  s1_t                     s1;
  logic [STAGES:1]         vld_pipe;
  logic                    last_grant;
  logic                    grant_vld, grant_ch, accept, pipe_en;
  logic [DATA_WIDTH-1:0]   dout_q, dout_nx;
  logic                    ch_q;
  logic [GAIN_WIDTH-1:0]   tgt, gain_nx;
  logic signed [PW-1:0]    prod, prod_adj, q;

  assign pipe_en = !(vld_pipe[STAGES] && !io.out_ready);

  always_comb begin
    grant_vld = io.l_valid || io.r_valid;
    grant_ch  = 1'b0;
    if (io.l_valid && io.r_valid) grant_ch = ~last_grant;
    else if (io.r_valid)          grant_ch = 1'b1;
  end

  assign accept     = pipe_en && grant_vld;
  assign io.l_ready = accept && !grant_ch;
  assign io.r_ready = accept &&  grant_ch;

  // Q10 dequantize rounds toward zero, so negative products get a 1023 bias before the shift.
  always_comb begin
    prod     = $signed({{(PW-DATA_WIDTH){s1.din[DATA_WIDTH-1]}}, s1.din})
             * $signed({{(PW-GAIN_WIDTH){1'b0}}, s1.gain});
    prod_adj = prod[PW-1] ? prod + RND : prod;
    q        = prod_adj >>> 10;
  end

`ifdef GAIN_SCHED_SAT_EN
  localparam logic signed [PW-1:0] SMAX = {{(PW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] SMIN = {{(PW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  logic signed [PW-1:0] qs;
  always_comb begin
    qs = q <<< OUT_SHIFT;
    if (qs > SMAX)      dout_nx = SMAX[DATA_WIDTH-1:0];
    else if (qs < SMIN) dout_nx = SMIN[DATA_WIDTH-1:0];
    else                dout_nx = qs[DATA_WIDTH-1:0];
  end
`else
  always_comb dout_nx = DATA_WIDTH'(q <<< OUT_SHIFT);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe   <= '0;
      s1         <= '0;
      dout_q     <= '0;
      ch_q       <= 1'b0;
      last_grant <= 1'b1;
    end else if (pipe_en) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], accept};
      if (accept) begin
        s1.din     <= grant_ch ? io.r_din : io.l_din;
        s1.ch      <= grant_ch;
        s1.gain    <= gain_cur;
        last_grant <= grant_ch;
      end
      if (vld_pipe[1]) begin
        dout_q <= dout_nx;
        ch_q   <= s1.ch;
      end
    end
  end

  assign io.out_dout  = dout_q;
  assign io.out_ch    = ch_q;
  assign io.out_valid = vld_pipe[STAGES];

  // Ramp one step per frame; the left sample of a pair already saw the pre-boundary gain.
  always_comb begin
    tgt     = mute ? '0 : target_gain;
    gain_nx = gain_cur;
    if (gain_cur < tgt)
      gain_nx = (tgt - gain_cur <= STEP) ? tgt : gain_cur + STEP;
    else if (gain_cur > tgt)
      gain_nx = (gain_cur - tgt <= STEP) ? tgt : gain_cur - STEP;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                 gain_cur <= '0;
    else if (accept && grant_ch)  gain_cur <= gain_nx;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= STEADY;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = STEADY;
    if (gain_cur < tgt)      state_nx = RAMP_UP;
    else if (gain_cur > tgt) state_nx = RAMP_DOWN;
    else if (mute)           state_nx = MUTED;
  end

  assign ramp_busy = (state == RAMP_UP) || (state == RAMP_DOWN);
  assign muted     = (state == MUTED);
endmodule

// File: tb/tb_gain_sched.sv
// Directed bench for gain_sched: ramp, rounding, arbitration, backpressure, mute, saturation, reset.
module tb_gain_sched;
  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] target_gain;
  logic        mute;
  logic [15:0] gain_cur;
  logic        ramp_busy, muted;

  gain_sched_if #(.DATA_WIDTH(32)) bus();

  gain_sched #(.DATA_WIDTH(32), .GAIN_WIDTH(16), .OUT_SHIFT(4), .RAMP_STEP(64)) dut (
    .clock(clock), .reset_n(reset_n), .io(bus.slave),
    .target_gain(target_gain), .mute(mute),
    .gain_cur(gain_cur), .ramp_busy(ramp_busy), .muted(muted)
  );

  always #5 clock = ~clock;

  int          n_vec = 0;
  int          n_err = 0;
  logic [32:0] oq[$];

`ifdef GAIN_SCHED_SAT_EN
  localparam logic [31:0] EXP_POS = 32'h7FFF_FFFF;
  localparam logic [31:0] EXP_NEG = 32'h8000_0000;
`else
  localparam logic [31:0] EXP_POS = 32'hFFFF_FFF0;
  localparam logic [31:0] EXP_NEG = 32'h0000_0000;
`endif

  // Capture every completed output transfer, sampled well clear of both edges.
  always @(negedge clock) begin
    #2;
    if (reset_n && bus.out_valid && bus.out_ready) oq.push_back({bus.out_ch, bus.out_dout});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send(input logic ch, input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    @(negedge clock);
    if (ch) begin bus.r_din = d; bus.r_valid = 1'b1; end
    else    begin bus.l_din = d; bus.l_valid = 1'b1; end
    for (int i = 0; i < 50 && !ok; i++) begin
      #1;
      if (ch ? bus.r_ready : bus.l_ready) ok = 1'b1;
      else @(negedge clock);
    end
    if (ok) @(posedge clock);
    #1;
    bus.l_valid = 1'b0;
    bus.r_valid = 1'b0;
    if (!ok) chk("send_accept", 32'(ok), 32'd1);
  endtask

  task automatic frame(input logic [31:0] l, input logic [31:0] r);
    send(1'b0, l);
    send(1'b1, r);
  endtask

  task automatic flush();
    repeat (4) @(negedge clock);
    #3;
    oq.delete();
  endtask

  task automatic expect_out(input string tag, input logic ch, input logic [31:0] d);
    logic [32:0] e;
    for (int i = 0; i < 20 && oq.size() == 0; i++) begin
      @(negedge clock);
      #3;
    end
    if (oq.size() == 0) chk({tag, "_avail"}, 32'(oq.size()), 32'd1);
    else begin
      e = oq.pop_front();
      chk({tag, "_ch"}, 32'(e[32]), 32'(ch));
      chk({tag, "_d"}, e[31:0], d);
    end
  endtask

  task automatic ramp_to(input logic [15:0] g);
    for (int i = 0; i < 24 && gain_cur != g; i++) frame(32'd0, 32'd0);
    flush();
    chk("ramp_to", 32'(gain_cur), 32'(g));
  endtask

  initial begin
    int lc, rc, g;
    bit acc_l, acc_r;

    reset_n = 1'b0; target_gain = 16'd256; mute = 1'b0;
    bus.l_din = '0; bus.l_valid = 1'b0; bus.r_din = '0; bus.r_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_dout",  bus.out_dout,        32'd0);
    chk("rst_ch",    32'(bus.out_ch),     32'd0);
    chk("rst_gain",  32'(gain_cur),       32'd0);
    chk("rst_busy",  32'(ramp_busy),      32'd0);
    chk("rst_muted", 32'(muted),          32'd0);
    reset_n = 1'b1;

    // Soft start toward 256: frames apply 0,64,128,192,256; din=1024 makes dout = 16*gain.
    for (int f = 0; f < 5; f++) begin
      g = 64 * f;
      frame(32'd1024, 32'd1024);
      expect_out("ramp_l", 1'b0, 32'(16 * g));
      expect_out("ramp_r", 1'b1, 32'(16 * g));
      if (f == 0) chk("ramp_busy_up", 32'(ramp_busy), 32'd1);
    end
    chk("ramp_gain256", 32'(gain_cur), 32'd256);
    chk("ramp_steady",  32'(ramp_busy), 32'd0);
    chk("ramp_nomute",  32'(muted),     32'd0);

    // Unity gain, 2-cycle latency, then rounding toward zero at 1024 and 512.
    target_gain = 16'd1024;
    ramp_to(16'd1024);
    send(1'b0, 32'd3);
    @(negedge clock);
    chk("lat_s1",   32'(bus.out_valid), 32'd0);
    @(negedge clock);
    chk("lat_out",  32'(bus.out_valid), 32'd1);
    chk("lat_dout", bus.out_dout,       32'd48);
    chk("lat_ch",   32'(bus.out_ch),    32'd0);
    send(1'b1, -32'sd5);
    expect_out("u_l3",  1'b0, 32'd48);
    expect_out("u_rm5", 1'b1, -32'sd80);
    target_gain = 16'd512;
    ramp_to(16'd512);
    frame(32'd3, -32'sd5);
    expect_out("h_l3",  1'b0, 32'd16);
    expect_out("h_rm5", 1'b1, -32'sd32);
    flush();

    // Continuous L/R streaming with a 3-cycle sink stall; L k -> 2k, R k -> 2(100+k), gain 512.
    lc = 0; rc = 0; acc_l = 1'b0; acc_r = 1'b0;
    bus.l_din = 32'd2; bus.r_din = 32'd202;
    for (int cyc = 0; cyc < 60 && !(lc == 8 && rc == 8); cyc++) begin
      @(negedge clock);
      if (acc_l) begin lc++; bus.l_din = 32'(2 * (lc + 1)); end
      if (acc_r) begin rc++; bus.r_din = 32'(2 * (101 + rc)); end
      bus.l_valid   = (lc < 8);
      bus.r_valid   = (rc < 8);
      bus.out_ready = !(cyc >= 6 && cyc < 9);
      #1;
      acc_l = bus.l_ready && bus.l_valid;
      acc_r = bus.r_ready && bus.r_valid;
      if (!bus.out_ready) begin
        chk("stall_lrdy",  32'(bus.l_ready),   32'd0);
        chk("stall_rrdy",  32'(bus.r_ready),   32'd0);
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
      end
    end
    bus.l_valid = 1'b0; bus.r_valid = 1'b0; bus.out_ready = 1'b1;
    chk("strm_cnt", 32'(lc + rc), 32'd16);
    for (int k = 1; k <= 8; k++) begin
      expect_out("strm_l", 1'b0, 32'(16 * k));
      expect_out("strm_r", 1'b1, 32'(16 * (100 + k)));
    end
    repeat (4) @(negedge clock);
    chk("strm_extra", 32'(oq.size()), 32'd0);

    // Soft mute from unity, then release.
    target_gain = 16'd1024;
    ramp_to(16'd1024);
    mute = 1'b1;
    frame(32'd0, 32'd0);
    chk("mute_step", 32'(gain_cur), 32'd960);
    repeat (2) @(negedge clock);
    chk("mute_busy",   32'(ramp_busy), 32'd1);
    chk("mute_notyet", 32'(muted),     32'd0);
    ramp_to(16'd0);
    chk("muted",       32'(muted),     32'd1);
    chk("muted_busy",  32'(ramp_busy), 32'd0);
    mute = 1'b0;
    frame(32'd0, 32'd0);
    chk("unmute_step", 32'(gain_cur), 32'd64);
    repeat (2) @(negedge clock);
    chk("unmute_muted", 32'(muted),     32'd0);
    chk("unmute_busy",  32'(ramp_busy), 32'd1);
    ramp_to(16'd1024);

    // Full-scale inputs at unity: wrap vs saturate.
    frame(32'h7FFF_FFFF, 32'h8000_0000);
    expect_out("fs_pos", 1'b0, EXP_POS);
    expect_out("fs_neg", 1'b1, EXP_NEG);
    flush();

    // Asynchronous reset mid-ramp with a sample in flight.
    target_gain = 16'd0;
    frame(32'd0, 32'd0);
    @(negedge clock);
    bus.l_din = 32'd5; bus.l_valid = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #3;
    chk("pre_rst_gain",  32'(gain_cur),      32'd960);
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_dout",  bus.out_dout,       32'd0);
    chk("arst_gain",  32'(gain_cur),      32'd0);
    chk("arst_busy",  32'(ramp_busy),     32'd0);
    chk("arst_muted", 32'(muted),         32'd0);
    bus.l_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
